// File: rtl/test_package.sv
// Shared types for the z_ing transmit path and its lane-array receivers.
package test_package;

    typedef struct packed {
        logic [3:0] cmd;
        logic [7:0] addr;
        logic [7:0] len;
    } z_ing;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

    // Receivers call this so they agree with the transmitter on beats per struct.
    function automatic int beats_of(input int zw, input int dsize);
        return (zw + dsize - 1) / dsize;
    endfunction

endpackage

// File: rtl/data_inf_c.sv
// Valid/ready/data stream lane shared by the lane-array producers and consumers.
interface data_inf_c #(
    parameter int DSIZE = 8
) ();
    logic             valid;
    logic             ready;
    logic [DSIZE-1:0] data;

    modport master (output valid, output data, input ready);
    modport slaver (input valid, input data, output ready);
endinterface

// File: rtl/stream_lane_demux.sv
// Steers one valid/data stream onto the selected lane of a master array and
// returns that lane's ready; unselected lanes are held at valid=0, data=0.
module stream_lane_demux #(
    parameter int DSIZE = 8,
    parameter int LANES = 5,
    parameter int LW    = 3
) (
    input  logic             valid,
    input  logic [DSIZE-1:0] data,
    input  logic [LW-1:0]    cur_lane,
    output logic             ready,
    data_inf_c.master        d_inf [LANES-1:0]
);

    logic [LANES-1:0] sel;
    logic [LANES-1:0] rdy_vec;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign sel[i]         = (cur_lane == LW'(i));
        assign d_inf[i].valid = valid & sel[i];
        assign d_inf[i].data  = (valid && sel[i]) ? data : '0;
        assign rdy_vec[i]     = d_inf[i].ready;
    end

    // Ready of unselected lanes never reaches the transmitter.
    assign ready = |(sel & rdy_vec);

endmodule

// File: rtl/z_ing_stream_tx.sv
// Serializes one z_ing struct per handshake LSB-first into DSIZE-bit beats,
// one whole struct per lane, lanes taken round-robin; counts sent structs.
module z_ing_stream_tx
    import test_package::*;
#(
    parameter int DSIZE = 8,
    parameter int LANES = 5
) (
    input  logic        clock,
    input  logic        rst_n,
    input  z_ing        struct_in,
    input  logic        struct_vld,
    output logic        struct_rdy,
    data_inf_c.master   d_inf [LANES-1:0],
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int ZW    = $bits(z_ing);
    localparam int BEATS = beats_of(ZW, DSIZE);
    localparam int SW    = BEATS * DSIZE;
    localparam int CW    = $clog2(BEATS + 1);
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    if (DSIZE != $bits(d_inf[0].data)) begin : g_dsize_chk
        $error("z_ing_stream_tx: DSIZE does not match lane data width");
    end

    tx_state_e       state_q;
    tx_state_e       state_d;
    logic [SW-1:0]   shreg_q;
    logic [CW-1:0]   beat_cnt_q;
    logic [LW-1:0]   cur_lane_q;
    logic [LW-1:0]   lane_ptr_q;
    logic [15:0]     frame_cnt_q;

    logic            lane_valid;
    logic            lane_ready;
    logic            accept;
    logic            fire;
    logic            last_beat;

    always_comb begin
        state_d    = state_q;
        struct_rdy = 1'b0;
        busy       = 1'b0;
        lane_valid = 1'b0;
        accept     = 1'b0;
        fire       = 1'b0;
        last_beat  = 1'b0;
        case (state_q)
            IDLE: begin
                struct_rdy = 1'b1;
                if (struct_vld) begin
                    accept  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                busy       = 1'b1;
                lane_valid = 1'b1;
                fire       = lane_ready;
                last_beat  = lane_ready && (beat_cnt_q == CW'(BEATS - 1));
                if (last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            cur_lane_q  <= '0;
            lane_ptr_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                beat_cnt_q <= '0;
                cur_lane_q <= lane_ptr_q;
            end else if (fire) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
            if (last_beat) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
                lane_ptr_q  <= (lane_ptr_q == LW'(LANES - 1)) ? '0 : lane_ptr_q + 1'b1;
            end
        end
    end

    // Payload register carries no reset: lane data is gated by valid downstream.
    always_ff @(posedge clock) begin
        if (accept) begin
            shreg_q <= SW'(struct_in);
        end else if (fire) begin
            shreg_q <= shreg_q >> DSIZE;
        end
    end

    assign frame_cnt = frame_cnt_q;

    stream_lane_demux #(
        .DSIZE (DSIZE),
        .LANES (LANES),
        .LW    (LW)
    ) u_demux (
        .valid    (lane_valid),
        .data     (shreg_q[DSIZE-1:0]),
        .cur_lane (cur_lane_q),
        .ready    (lane_ready),
        .d_inf    (d_inf)
    );

endmodule

// File: tb/tb_z_ing_stream_tx.sv
// Directed bench for z_ing_stream_tx with DSIZE=8, LANES=5 (20-bit struct, 3 beats).
module tb_z_ing_stream_tx;
    import test_package::*;

    logic        clock;
    logic        rst_n;
    z_ing        struct_in;
    logic        struct_vld;
    logic        struct_rdy;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [4:0]  rdy_tb;
    logic [4:0]  vld_mon;
    logic [39:0] dat_mon;

    int errors = 0;
    int checks = 0;

    data_inf_c #(.DSIZE(8)) lanes [4:0] ();

    for (genvar i = 0; i < 5; i++) begin : g_mon
        assign lanes[i].ready   = rdy_tb[i];
        assign vld_mon[i]       = lanes[i].valid;
        assign dat_mon[8*i +: 8] = lanes[i].data;
    end

    z_ing_stream_tx #(.DSIZE(8), .LANES(5)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .struct_in  (struct_in),
        .struct_vld (struct_vld),
        .struct_rdy (struct_rdy),
        .d_inf      (lanes),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [19:0] s;
        int          lane;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst_n = 1'b0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic check_beat(input string tag, input int lane, input logic [7:0] b);
        check({tag, " valid"}, 64'(vld_mon), 64'(5'b1 << lane));
        check({tag, " data"}, 64'(dat_mon), 64'(40'(b) << (8 * lane)));
        check({tag, " rdy"}, 64'(struct_rdy), 64'd0);
    endtask

    // Entered and left at a negedge in IDLE; exercises one full struct with ready high.
    task automatic send_chk(input logic [19:0] s, input int lane,
                            input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] bk [3];
        bk[0] = b0; bk[1] = b1; bk[2] = b2;
        check("pre rdy", 64'(struct_rdy), 64'd1);
        struct_in  = z_ing'(s);
        struct_vld = 1'b1;
        @(posedge clock);
        @(negedge clock);
        struct_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_beat($sformatf("beat%0d lane%0d", k, lane), lane, bk[k]);
            check("busy", 64'(busy), 64'd1);
            @(posedge clock);
            @(negedge clock);
        end
        check("idle valid", 64'(vld_mon), 64'd0);
        check("idle rdy", 64'(struct_rdy), 64'd1);
        check("idle busy", 64'(busy), 64'd0);
    endtask

    initial begin
        vecs[0] = '{s: 20'h5A5A5, lane: 0, b0: 8'hA5, b1: 8'hA5, b2: 8'h05};
        vecs[1] = '{s: 20'h12345, lane: 1, b0: 8'h45, b1: 8'h23, b2: 8'h01};
        vecs[2] = '{s: 20'hFFFFF, lane: 2, b0: 8'hFF, b1: 8'hFF, b2: 8'h0F};
        vecs[3] = '{s: 20'h00000, lane: 3, b0: 8'h00, b1: 8'h00, b2: 8'h00};
        vecs[4] = '{s: 20'hABCDE, lane: 4, b0: 8'hDE, b1: 8'hBC, b2: 8'h0A};
        vecs[5] = '{s: 20'h80001, lane: 0, b0: 8'h01, b1: 8'h00, b2: 8'h08};

        rst_n      = 1'b0;
        struct_vld = 1'b0;
        struct_in  = '0;
        rdy_tb     = 5'b11111;
        do_reset();

        check("reset rdy", 64'(struct_rdy), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset valid", 64'(vld_mon), 64'd0);
        check("reset data", 64'(dat_mon), 64'd0);
        check("reset frame_cnt", 64'(frame_cnt), 64'd0);

        // Single struct then round-robin wrap, back-to-back.
        for (int v = 0; v < 6; v++) begin
            send_chk(vecs[v].s, vecs[v].lane, vecs[v].b0, vecs[v].b1, vecs[v].b2);
            if (v == 0) begin
                check("first frame_cnt", 64'(frame_cnt), 64'd1);
                check("first lane_ptr", 64'(dut.lane_ptr_q), 64'd1);
            end
        end
        check("rr frame_cnt", 64'(frame_cnt), 64'd6);

        // Reset mid-struct: lane 1 after the six above.
        struct_in  = z_ing'(20'h2468A);
        struct_vld = 1'b1;
        @(posedge clock);
        @(negedge clock);
        struct_vld = 1'b0;
        check_beat("midrst beat0", 1, 8'h8A);
        @(posedge clock);
        #2 rst_n = 1'b0;
        #1;
        check("midrst valid", 64'(vld_mon), 64'd0);
        check("midrst data", 64'(dat_mon), 64'd0);
        check("midrst rdy", 64'(struct_rdy), 64'd1);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst frame_cnt", 64'(frame_cnt), 64'd0);
        @(negedge clock);
        rst_n = 1'b1;
        send_chk(20'h13579, 0, 8'h79, 8'h35, 8'h01);
        check("post-rst frame_cnt", 64'(frame_cnt), 64'd1);

        // Backpressure on lane 0 during beat 1.
        do_reset();
        struct_in  = z_ing'(20'hC3D2E);
        struct_vld = 1'b1;
        @(posedge clock);
        @(negedge clock);
        struct_vld = 1'b0;
        check_beat("bp beat0", 0, 8'h2E);
        @(posedge clock);
        @(negedge clock);
        rdy_tb[0] = 1'b0;
        check_beat("bp beat1 start", 0, 8'h3D);
        for (int c = 0; c < 4; c++) begin
            @(posedge clock);
            @(negedge clock);
            check_beat($sformatf("bp hold%0d", c), 0, 8'h3D);
        end
        rdy_tb[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_beat("bp beat2", 0, 8'h0C);
        @(posedge clock);
        @(negedge clock);
        check("bp idle rdy", 64'(struct_rdy), 64'd1);
        check("bp frame_cnt", 64'(frame_cnt), 64'd1);

        // Stalled lane 2 blocks the third struct.
        do_reset();
        rdy_tb = 5'b11011;
        send_chk(20'h11111, 0, 8'h11, 8'h11, 8'h01);
        send_chk(20'h22222, 1, 8'h22, 8'h22, 8'h02);
        struct_in  = z_ing'(20'h76543);
        struct_vld = 1'b1;
        @(posedge clock);
        @(negedge clock);
        struct_vld = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check_beat($sformatf("stall%0d", c), 2, 8'h43);
            @(posedge clock);
            @(negedge clock);
        end
        rdy_tb[2] = 1'b1;
        check_beat("stall release beat0", 2, 8'h43);
        @(posedge clock);
        @(negedge clock);
        check_beat("stall beat1", 2, 8'h65);
        @(posedge clock);
        @(negedge clock);
        check_beat("stall beat2", 2, 8'h07);
        @(posedge clock);
        @(negedge clock);
        check("stall idle rdy", 64'(struct_rdy), 64'd1);
        check("stall frame_cnt", 64'(frame_cnt), 64'd3);

        // Counter wrap.
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        check("wrap preload", 64'(frame_cnt), 64'hFFFF);
        send_chk(20'h0F0F0, 3, 8'hF0, 8'hF0, 8'h00);
        check("wrap frame_cnt", 64'(frame_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/z_ing_stream_tx.md
# z_ing_stream_tx

Transmit-side companion to the `data_inf_c.slaver` lane-array consumers: accepts one `z_ing` struct per handshake and serializes it LSB-first into `DSIZE`-bit beats on one lane of a `data_inf_c.master` array. Lanes are chosen round-robin, one whole struct per lane. It sits between struct-producing control logic and the 5-lane stream fabric. It also counts completed structs.

## Interface
- `DSIZE`, 8, beat width; must equal the width of `d_inf[*].data`.
- `LANES`, 5, number of master lanes in `d_inf`.
- Derived `ZW` = `$bits(z_ing)`.
- Derived `BEATS` = `(ZW+DSIZE-1)/DSIZE`.
- Derived `CW` = `$clog2(BEATS+1)`.
- `clock`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `struct_in`  in  `z_ing`  struct to send; sampled on accept.
- `struct_vld`  in  1  `struct_in` valid.
- `struct_rdy`  out  1  block can accept a struct.
- `d_inf`  `data_inf_c.master`  `[LANES-1:0]`  output lanes; this block drives `valid` and `data`, and samples `ready`.
- `busy`  out  1  a struct is being serialized.
- `frame_cnt`  out  16  count of fully sent structs; wraps.

## Operation
- FSM has two states, IDLE and SEND.
- **IDLE:**
  - `struct_rdy`=1.
  - On `struct_vld`=1, capture `struct_in` into a `BEATS*DSIZE`-bit shift register. The upper `BEATS*DSIZE-ZW` bits are zero-padded.
  - Set `beat_cnt`=0, set `cur_lane`=`lane_ptr`, go to SEND.
- **SEND:**
  - `struct_rdy`=0 and `busy`=1.
  - `d_inf[cur_lane].valid`=1 and `d_inf[cur_lane].data`=`shreg[DSIZE-1:0]`.
  - Every other lane has `valid`=0 and `data`=0.
- **Beat transfer:** a beat moves when `valid` and `ready` are both high on the same edge. On transfer, shift `shreg` right by `DSIZE` and increment `beat_cnt`.
- **Last beat** (`beat_cnt`==`BEATS-1` and transfer):
  - Go to IDLE and increment `frame_cnt`.
  - Advance `lane_ptr`, wrapping from `LANES-1` to 0.
- **Holding:** `valid` is never deasserted mid-struct. `data` stays stable while `valid`=1 and `ready`=0.
- **Lane selection:** there is no lane skipping. A stalled lane blocks the block; the fabric owns backpressure.
- **Ready usage:** `ready` of non-selected lanes is ignored.
- **Data path:** the struct passes through bit-exact. Beat k carries `struct_in[k*DSIZE +: DSIZE]`.
- **Reset mid-struct:** everything returns to reset values immediately. The partial struct is dropped and `frame_cnt` is not incremented.

## Timing
- **Reset values:**
  - state=IDLE, `struct_rdy`=1, `busy`=0.
  - All `d_inf[*].valid`=0 and all `data`=0.
  - `lane_ptr`=0, `frame_cnt`=0.
- **Latency:** accept edge to first `valid` is 1 cycle. With `ready` held high, one struct occupies `BEATS` cycles in SEND.
- **Throughput:** back-to-back structs cost `BEATS+1` cycles each, because of the one IDLE cycle. Required throughput is that IDLE bubble.
- **Combinational paths:** `struct_rdy` has no combinational path from `ready` or `struct_vld`. All outputs are registered or decoded from registered state.
- **`frame_cnt`:** wraps from 16'hFFFF to 0.
- **`BEATS`==1:** SEND lasts one beat; the IDLE/SEND alternation is unchanged.

## Structure
- `z_ing` comes from the shared `test_package`, imported in the module header.
- Add `z_ing_stream_tx_pkg` items to `test_package`:
  - a `tx_state_e` enum (IDLE, SEND);
  - a function `beats_of(int zw, int dsize)` so receivers compute the same `BEATS`.
- One natural sub-module, `stream_lane_demux`. It takes one valid/data/ready triple plus `cur_lane` and fans out to the `data_inf_c.master` array, returning the selected `ready`.
- Include an elaboration check that `DSIZE == $bits(d_inf[0].data)`.

## Test plan
All scenarios use `DSIZE`=8 and `LANES`=5.
- **Single struct, `ready`=1 on all lanes:**
  - Stimulus: `struct_in` = alternating 8'hA5 bytes.
  - Required: lane 0 shows `BEATS` consecutive beats, beat k = `struct_in[8k+:8]`, and the last beat's pad bits are 0.
  - Required after the last beat: `frame_cnt`=1 and `lane_ptr`=1.
- **Round-robin wrap:**
  - Stimulus: 6 back-to-back structs.
  - Required: they appear on lanes 0,1,2,3,4,0, with exactly one idle cycle between structs, and `frame_cnt`=6.
- **Backpressure:**
  - Stimulus: hold lane 0 `ready`=0 for 4 cycles during beat 1.
  - Required: `valid`=1 and `data`=`struct_in[15:8]` are constant throughout, `struct_rdy`=0, and no other lane asserts `valid`.
- **Reset mid-struct:**
  - Stimulus: assert `rst_n`=0 asynchronously after beat 0 transfers.
  - Required: outputs reach reset values without waiting for a clock edge, and `frame_cnt`=0.
  - Required after release: the next struct goes to lane 0, starting at beat 0.
- **Stalled-lane isolation:**
  - Stimulus: lane 2 `ready`=0 and other lanes `ready`=1.
  - Required: after 2 structs the third sits on lane 2 and `struct_rdy` stays 0 until lane 2 `ready` rises.
- **Counter wrap:**
  - Stimulus: preload via force, or run 65536 structs.
  - Required: `frame_cnt` goes from 16'hFFFF to 16'h0000.
